// File: rtl/frida_pkg.sv
// Shared FRIDA definitions: scan FSM encoding and default array geometry.
package frida_pkg;

   localparam int FRIDA_N_CH   = 16;
   localparam int FRIDA_N_BITS = 12;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      SETTLE,
      ACQ,
      PUSH
   } scan_state_t;

endpackage

// File: rtl/frida_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push and pop may coincide even when full.
module frida_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees the slot the simultaneous push lands in, so full does not block it.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately left unreset; stale entries are never visible because the read port is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/comp_scan_ctrl.sv
// Comparator scan controller: walks the enabled ADC channels, assembles serial
// comparator decisions into {channel, result} words and buffers them for readout.
module comp_scan_ctrl
   import frida_pkg::*;
#(
   parameter  int N_CH       = FRIDA_N_CH,
   parameter  int N_BITS     = FRIDA_N_BITS,
   parameter  int FIFO_DEPTH = 8,
   localparam int SEL_W      = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    cont,
   input  logic [N_CH-1:0]         ch_mask,
   input  logic                    conv_strobe,
   input  logic [N_CH-1:0]         comp_in,
   output logic [SEL_W-1:0]        mux_sel,
   output logic                    busy,
   output logic [SEL_W+N_BITS-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overflow,
   input  logic                    clr_overflow
);

   localparam int CNT_W = $clog2(N_BITS);

   scan_state_t       state;
   scan_state_t       state_next;
   logic [N_CH-1:0]   mask_q;
   logic              cont_q;
   logic [SEL_W-1:0]  cur_ch;
   logic [N_BITS-1:0] shift_q;
   logic [CNT_W-1:0]  bit_cnt;

   logic [N_CH-1:0]   above;
   logic [SEL_W-1:0]  next_ch;
   logic [SEL_W-1:0]  first_ch;
   logic [SEL_W-1:0]  wrap_ch;
   logic              wrap;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              last_strobe;

   function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] v);
      lowest_set = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = SEL_W'(i);
      end
   endfunction

   // Next-channel search: enabled channels strictly above the current one.
   always_comb begin
      above = '0;
      for (int i = 0; i < N_CH; i++) begin
         above[i] = mask_q[i] && (i > int'(cur_ch));
      end
   end

   assign next_ch     = lowest_set(above);
   assign wrap        = (above == '0);
   assign wrap_ch     = lowest_set(mask_q);
   assign first_ch    = lowest_set(ch_mask);
   assign last_strobe = conv_strobe && (bit_cnt == CNT_W'(N_BITS - 1));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      fifo_push  = 1'b0;
      case (state)
         IDLE:    if (start && (ch_mask != '0)) state_next = SELECT;
         SELECT:  state_next = SETTLE;
         SETTLE:  state_next = ACQ;
         ACQ:     if (last_strobe) state_next = PUSH;
         PUSH: begin
            fifo_push  = 1'b1;
            state_next = (!wrap || cont_q) ? SELECT : IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (stop && (state != IDLE)) state_next = IDLE;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         mask_q  <= '0;
         cont_q  <= 1'b0;
         cur_ch  <= '0;
         mux_sel <= '0;
         shift_q <= '0;
         bit_cnt <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start && (ch_mask != '0)) begin
                  mask_q <= ch_mask;
                  cont_q <= cont;
                  cur_ch <= first_ch;
               end
            end
            SELECT: begin
               mux_sel <= cur_ch;
               shift_q <= '0;
               bit_cnt <= '0;
            end
            ACQ: begin
               if (conv_strobe) begin
                  shift_q <= {shift_q[N_BITS-2:0], comp_in[mux_sel]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PUSH:    cur_ch <= wrap ? wrap_ch : next_ch;
            default: ;
         endcase
      end
   end

   assign fifo_pop  = out_valid && out_ready;
   assign out_valid = !fifo_empty;

   // A dropped word outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        overflow <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)   overflow <= 1'b1;
      else if (clr_overflow)                          overflow <= 1'b0;
   end

   frida_sync_fifo #(
      .WIDTH (SEL_W + N_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({mux_sel, shift_q}),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_comp_scan_ctrl.sv
// Self-checking bench for comp_scan_ctrl against a queue-based scan/FIFO model.
module tb_comp_scan_ctrl;

   localparam int N_CH  = 16;
   localparam int N_BITS = 12;
   localparam int DEPTH = 8;
   localparam int SEL_W = 4;
   localparam int DW    = SEL_W + N_BITS;

   logic            clk = 1'b0;
   logic            rst, start, stop, cont, conv_strobe, out_ready, clr_overflow;
   logic [N_CH-1:0] ch_mask, comp_in;
   logic [SEL_W-1:0] mux_sel;
   logic            busy, out_valid, overflow;
   logic [DW-1:0]   out_data;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] exp_q[$];
   logic          exp_ovf;
   logic [DW-1:0] pend;

   always #5 clk = ~clk;

   comp_scan_ctrl #(.N_CH(N_CH), .N_BITS(N_BITS), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .cont         (cont),
      .ch_mask      (ch_mask),
      .conv_strobe  (conv_strobe),
      .comp_in      (comp_in),
      .mux_sel      (mux_sel),
      .busy         (busy),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_scan(input logic [N_CH-1:0] mask, input logic c);
      ch_mask = mask;
      cont    = c;
      start   = 1'b1;
      step();
      start   = 1'b0;
      ch_mask = 16'($urandom);
      cont    = 1'($urandom);
      check("busy_start", busy, 1);
   endtask

   // Two cycles (SELECT, SETTLE); junk strobes here must be ignored.
   task automatic to_acq(input logic junk);
      repeat (2) begin
         conv_strobe = junk;
         comp_in     = 16'($urandom);
         step();
      end
      conv_strobe = 1'b0;
   endtask

   // Feeds N_BITS decisions for channel ch; returns in the PUSH cycle.
   task automatic do_channel(input int ch, input logic fixed, input logic [N_BITS-1:0] pattern);
      logic [N_BITS-1:0] bits;
      logic              b;
      bits = '0;
      check("mux_sel_acq", mux_sel, ch);
      check("busy_acq", busy, 1);
      for (int k = 0; k < N_BITS; k++) begin
         repeat ($urandom_range(0, 2)) begin
            conv_strobe = 1'b0;
            comp_in     = 16'($urandom);
            step();
         end
         b           = fixed ? pattern[N_BITS-1-k] : 1'($urandom);
         comp_in     = 16'($urandom);
         comp_in[ch] = b;
         conv_strobe = 1'b1;
         step();
         bits = {bits[N_BITS-2:0], b};
      end
      conv_strobe = 1'b0;
      pend = {SEL_W'(ch), bits};
   endtask

   // Model of the PUSH cycle: optional pop, optional overflow clear.
   task automatic finish_push(input logic clr, input logic rdy, input logic junk);
      logic was_full, popped;
      conv_strobe  = junk;
      comp_in      = 16'($urandom);
      out_ready    = rdy;
      clr_overflow = clr;
      was_full = (exp_q.size() == DEPTH);
      popped   = rdy && (exp_q.size() > 0);
      if (popped) void'(exp_q.pop_front());
      if (!was_full || popped) exp_q.push_back(pend);
      else                     exp_ovf = 1'b1;
      if (clr && !(was_full && !popped)) exp_ovf = 1'b0;
      step();
      conv_strobe  = 1'b0;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      check("overflow_push", overflow, exp_ovf);
      check("out_valid_push", out_valid, exp_q.size() != 0);
   endtask

   task automatic run_scan(input logic [N_CH-1:0] mask, input logic junk, input logic fixed,
                           input logic [N_BITS-1:0] pattern, input int clr_idx, input int rdy_idx,
                           input int nrun);
      int chans[$];
      int n;
      for (int i = 0; i < N_CH; i++) if (mask[i]) chans.push_back(i);
      n = (nrun > 0) ? nrun : chans.size();
      start_scan(mask, 1'b0);
      for (int k = 0; k < n; k++) begin
         to_acq(junk);
         do_channel(chans[k], fixed, pattern);
         finish_push(k == clr_idx, k == rdy_idx, junk);
      end
      if (n < chans.size()) begin
         stop = 1'b1;
         step();
         stop = 1'b0;
      end
      check("busy_end", busy, 0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      while (exp_q.size() > 0) begin
         check("drain_valid", out_valid, 1);
         check("drain_data", out_data, exp_q[0]);
         step();
         void'(exp_q.pop_front());
      end
      out_ready = 1'b0;
      check("drain_empty_valid", out_valid, 0);
      check("drain_empty_data", out_data, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = '0;
      conv_strobe = 1'b0; comp_in = '0; out_ready = 1'b0; clr_overflow = 1'b0;
      exp_ovf = 1'b0; pend = '0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_mux_sel", mux_sel, 0);
      check("rst_data", out_data, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b0;
      step();

      // Single scan of channels 0 and 2 with fixed decisions 0xA5A.
      run_scan(16'h0005, 1'b0, 1'b1, 12'hA5A, -1, -1, 0);
      drain();

      // Strobes during PUSH/SELECT/SETTLE are ignored.
      run_scan(16'h0410, 1'b1, 1'b0, '0, -1, -1, 0);
      drain();

      // Overflow: 8 stored, 9th dropped, 10th dropped with clr (set wins).
      run_scan(16'hFFFF, 1'b0, 1'b0, '0, 9, -1, 10);
      check("ovf_sticky", overflow, 1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      exp_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      drain();

      // Full FIFO with a pop in the PUSH cycle: word accepted, no overflow.
      run_scan(16'h01FF, 1'b0, 1'b0, '0, -1, 8, 0);
      check("full_pop_ovf", overflow, 0);
      drain();

      // Continuous scan 0,15,0,15 then stop mid-ACQ.
      start_scan(16'h8001, 1'b1);
      for (int k = 0; k < 4; k++) begin
         to_acq(1'b0);
         do_channel((k % 2 == 0) ? 0 : 15, 1'b0, '0);
         finish_push(1'b0, 1'b0, 1'b0);
         check("cont_busy", busy, 1);
      end
      to_acq(1'b0);
      check("cont_wrap_sel", mux_sel, 0);
      repeat (5) begin
         conv_strobe = 1'b1;
         comp_in     = 16'($urandom);
         step();
      end
      conv_strobe = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      repeat (3) step();
      check("stop_busy_hold", busy, 0);
      drain();

      // Randomized masks of up to eight channels.
      for (int r = 0; r < 4; r++) begin
         logic [N_CH-1:0] m;
         m = 16'($urandom_range(1, 255) << $urandom_range(0, 8));
         run_scan(m, 1'($urandom), 1'b0, '0, -1, -1, 0);
         drain();
      end

      // Reset mid-ACQ with a word already buffered.
      start_scan(16'h0003, 1'b0);
      to_acq(1'b0);
      do_channel(0, 1'b0, '0);
      finish_push(1'b0, 1'b0, 1'b0);
      to_acq(1'b0);
      repeat (4) begin
         conv_strobe = 1'b1;
         comp_in     = 16'($urandom);
         step();
      end
      conv_strobe = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_data", out_data, 0);
      check("midrst_mux_sel", mux_sel, 0);
      check("midrst_overflow", overflow, 0);
      exp_q.delete();
      exp_ovf = 1'b0;
      #3 rst = 1'b0;
      step();
      ch_mask = '0;
      start   = 1'b1;
      step();
      start   = 1'b0;
      check("zero_mask_busy", busy, 0);
      step();
      check("zero_mask_busy2", busy, 0);
      check("zero_mask_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/comp_scan_ctrl.md
# comp_scan_ctrl

Parametrised successor to the fixed 16:1 comparator mux in the FRIDA core. It sequences the comparator-output mux across a programmable subset of the ADC channels. For each selected channel it assembles N_BITS serial comparator decisions into a result word, tagged with the channel index. Words are buffered in a small FIFO with valid/ready readout, so one digital output can drain any number of channels without external mux_sel control.

## Interface
- N_CH, 16: number of ADC channels / comparator inputs (≥2)
- N_BITS, 12: comparator decisions per conversion (≥2)
- FIFO_DEPTH, 8: result FIFO entries (power of two, ≥2)
- SEL_W, $clog2(N_CH): derived, not overridden

- clk  in  1  digital clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan
- stop  in  1  one-cycle pulse; aborts the scan at the next cycle
- cont  in  1  sampled at start; 1 = wrap and rescan until stop
- ch_mask  in  N_CH  channel enable mask; sampled at start
- conv_strobe  in  1  one-cycle pulse per comparator decision; already synchronised to clk
- comp_in  in  N_CH  per-ADC comparator outputs; valid when conv_strobe=1
- mux_sel  out  SEL_W  channel currently routed to the decision path
- busy  out  1  scan in progress
- out_data  out  SEL_W+N_BITS  {channel, result}; result MSB is the first decision
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid=1
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- clr_overflow  in  1  clears overflow

## Operation
- FSM states: IDLE, SELECT, SETTLE, ACQ, PUSH.
- IDLE to SELECT on start with ch_mask≠0. start with ch_mask=0 is ignored.
  - Latches mask_q, cont_q.
  - Current channel is the lowest set bit of mask_q.
- SELECT: drives mux_sel to the current channel, clears shift reg and bit counter. Then SETTLE.
- SETTLE: one cycle for the mux to settle. conv_strobe is ignored in SELECT and SETTLE. Then ACQ.
- ACQ: on each conv_strobe, result <= {result[N_BITS-2:0], comp_in[mux_sel]} and the bit counter increments. When the N_BITS-th strobe is taken, go to PUSH.
- PUSH, one cycle: write {mux_sel, result} to the FIFO.
  - If the FIFO is full and no pop happens that cycle, drop the word and set overflow.
  - Next state is SELECT on the next higher set bit of mask_q.
  - After the highest set bit: SELECT on the lowest set bit if cont_q=1, else IDLE.
- stop in any non-IDLE state goes to IDLE next cycle. A partial result is discarded; FIFO contents are kept.
- start while busy is ignored.
- FIFO is first-word-fall-through: out_data is valid whenever out_valid=1.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle is legal at every occupancy, including full; occupancy is unchanged.
- overflow: set by a dropped push; cleared by clr_overflow. If both happen in the same cycle, set wins.
- busy=1 in every state except IDLE.

## Timing
- Reset values: state=IDLE, mux_sel=0, busy=0, out_valid=0, out_data=0, overflow=0. FIFO is emptied, counters are zeroed.
- start at cycle 0: busy=1 and SELECT at cycle 1, mux_sel updated at cycle 2, ACQ from cycle 3.
- The earliest accepted strobe is the first one seen in ACQ.
- Last strobe at cycle t: PUSH at t+1, out_valid=1 at t+2 if the FIFO was empty.
- Channel-to-channel overhead: 3 cycles (PUSH, SELECT, SETTLE) plus acquisition time.
- conv_strobe arriving during PUSH is dropped; the upstream sequencer guarantees ≥4 cycles between the last strobe of one channel and the first of the next.
- rst asserted mid-scan: immediate return to reset values; no partial word is written.

## Structure
- Shared package frida_pkg holds:
  - typedef scan_state_t (the FSM enum)
  - default constants FRIDA_N_CH=16, FRIDA_N_BITS=12
- Next-channel search is a priority encoder over mask_q with channels ≤ current masked off, plus a wrap flag. It is combinational and lives inside this module.
- One sub-module: frida_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty.
  - Pointers are one bit wider than the address for the full/empty test.

## Test plan
- Single scan: ch_mask=16'h0005, cont=0, comp_in pattern 0xA5A. Expect two words, {0,0xA5A} then {2,0xA5A}. busy drops one cycle after the second PUSH.
- Strobes in SELECT/SETTLE: send a strobe one cycle after start. Expect it ignored; the result equals the 12 subsequent decisions.
- Overflow: FIFO_DEPTH=8, out_ready=0, ch_mask=16'hFFFF.
  - Expect 8 words stored and overflow=1 after the 9th PUSH.
  - clr_overflow while a push is dropped keeps overflow=1.
- Full with simultaneous pop: FIFO full, out_ready=1 during PUSH. Expect the word accepted, occupancy stays 8, overflow stays 0.
- Continuous and stop: ch_mask=16'h8001, cont=1. Expect channel order 0,15,0,15.
  - stop mid-ACQ: IDLE next cycle, no partial word, FIFO contents retained.
- Reset mid-scan: assert rst during ACQ. Expect all outputs at reset values immediately and out_valid=0. A following start with ch_mask=0 leaves busy=0.
